tcs3200_color_detector: RTL and testbench
=========================================

Name: tcs3200_color_detector

Overview:
Produces the 2-bit color_code consumed by the 7-segment output stage. It drives the TCS3200 photodiode filter-select lines (S2/S3) and counts rising edges of the sensor's frequency output over a fixed gate window for red, green and blue in turn. It then classifies the dominant color. The block sits between the sensor pins and the display driver, with a start/busy/valid handshake toward control logic.

Parameters:
GATE_CYCLES, 500000, clk cycles per measurement window (10 ms at 50 MHz)
SETTLE_CYCLES, 5000, clk cycles waited after changing S2/S3 before counting
CNT_W, 16, width of each edge counter and count output
MIN_COUNT, 50, minimum winning count for a valid color; below this the result is unknown

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  request one R/G/B measurement; sampled only in IDLE
sensor_out  in  1  TCS3200 OUT pin, asynchronous square wave
s2  out  1  filter select S2
s3  out  1  filter select S3
busy  out  1  high while a measurement is in progress
color_code  out  2  00 red, 01 green, 10 blue, 11 unknown
color_valid  out  1  one-cycle pulse when color_code is updated
red_cnt  out  CNT_W  latched red edge count from the last completed measurement
green_cnt  out  CNT_W  latched green edge count
blue_cnt  out  CNT_W  latched blue edge count

Behaviour:
- Input conditioning: sensor_out passes through a 2-FF synchronizer. A rising edge is detected when the synchronized signal is 1 and its previous registered value is 0. Edge detection runs every cycle.
- Filter mapping: red S2S3=00, green S2S3=11, blue S2S3=01.
- FSM states: IDLE, SET_R, MEAS_R, SET_G, MEAS_G, SET_B, MEAS_B, DECIDE.
  - IDLE: s2=0, s3=0, busy=0. start=1 moves to SET_R and clears the working counters.
  - SET_x: drives the S2/S3 value for that filter. Stays SETTLE_CYCLES cycles, then moves to MEAS_x. Edges seen here are ignored.
  - MEAS_x: S2/S3 held. Each detected edge increments the x counter. Stays GATE_CYCLES cycles, then advances R→G→B→DECIDE.
  - DECIDE: one cycle, then returns to IDLE.
- Counter width: each counter saturates at 2^CNT_W−1 and never wraps.
- Timer: one shared down-counter, reloaded on every state entry.
- busy=1 in every state except IDLE. start is ignored while busy.
- Classification (on the edge leaving DECIDE):
  - Winner is the strictly largest of the three counts.
  - If two or more counts tie for the maximum, color_code=11.
  - If the winning count is below MIN_COUNT, color_code=11.
  - On the same edge: color_valid=1 for exactly one cycle, and red_cnt/green_cnt/blue_cnt are latched from the working counters.
- Latency: color_valid is high exactly 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles after the edge that sampled start.
- Between measurements: color_code and the count outputs hold their values until the next DECIDE.
- Back-to-back: start held high in IDLE immediately after DECIDE begins a new measurement. This gives continuous mode with one IDLE cycle between runs.
- Reset values: FSM=IDLE, s2=0, s3=0, busy=0, color_code=11, color_valid=0, all counts=0, synchronizer flops=0.
- Reset mid-measurement: aborts with no color_valid pulse; outputs return to their reset values.
- Simultaneous rst and start: rst wins.

Test Plan:
(Bench overrides: GATE_CYCLES=100, SETTLE_CYCLES=10, MIN_COUNT=4, CNT_W=8.)
1. Red dominant: sensor period 10 clk while s2s3=00, period 40 otherwise; pulse start → red_cnt 10±1, green/blue 2–3, color_code=00, color_valid pulse at cycle 331 after start.
2. Blue dominant: period 8 in blue, 25 in red/green → color_code=10, s2s3 sequence 00→11→01 observed with correct dwell times, busy low again after valid.
3. Tie and dark: identical period 10 for all filters → color_code=11. Then sensor held 0 → all counts 0, color_code=11.
4. Saturation: CNT_W=4, period 2 in green, 10 elsewhere → green_cnt=15 (no wrap), color_code=01.
5. Handshake: start pulsed again at cycle 50 of a run → ignored, single valid pulse. Start held high continuously → valid pulses every 332 cycles.
6. Reset mid-run: assert rst during MEAS_G for 1 cycle → no color_valid, color_code=11, counts 0, busy=0, s2s3=00. A fresh start then completes normally.

Source files
------------

// File: rtl/tcs3200_color_detector.sv
// tcs3200_color_detector: steps the TCS3200 filter selects through red, green
// and blue, counts sensor output edges over a fixed gate window for each, and
// classifies the dominant color for the display stage.
module tcs3200_color_detector #(
  parameter int unsigned GATE_CYCLES   = 500000,
  parameter int unsigned SETTLE_CYCLES = 5000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sensor_out,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic [1:0]       color_code,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  // Shared timer only ever holds (longest dwell - 1).
  localparam int unsigned MaxCycles = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] GateLoad   = TimerW'(GATE_CYCLES - 1);
  localparam logic [TimerW-1:0] SettleLoad = TimerW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax     = {CNT_W{1'b1}};

  localparam logic [1:0] CodeRed     = 2'b00;
  localparam logic [1:0] CodeGreen   = 2'b01;
  localparam logic [1:0] CodeBlue    = 2'b10;
  localparam logic [1:0] CodeUnknown = 2'b11;

  // Filter selects as {s2, s3}.
  localparam logic [1:0] SelRed   = 2'b00;
  localparam logic [1:0] SelGreen = 2'b11;
  localparam logic [1:0] SelBlue  = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StSetR,
    StMeasR,
    StSetG,
    StMeasG,
    StSetB,
    StMeasB,
    StDecide
  } state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic              timer_done;

  logic [1:0]        sync_q;
  logic              sensor_prev_q;
  logic              sensor_rise;

  logic [CNT_W-1:0]  work_r_q;
  logic [CNT_W-1:0]  work_g_q;
  logic [CNT_W-1:0]  work_b_q;

  logic [CNT_W-1:0]  max_cnt;
  logic [1:0]        code_d;

  // Saturating increment: a bright sensor must pin the count, never wrap it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchronizer on the asynchronous sensor pin plus a history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= 2'b00;
      sensor_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], sensor_out};
      sensor_prev_q <= sync_q[1];
    end
  end

  assign sensor_rise = sync_q[1] & ~sensor_prev_q;
  assign timer_done  = (timer_q == '0);

  // Dominant-color decision from the working counters; ties and dim readings are unknown.
  always_comb begin
    max_cnt = work_r_q;
    if (work_g_q > max_cnt) max_cnt = work_g_q;
    if (work_b_q > max_cnt) max_cnt = work_b_q;

    code_d = CodeUnknown;
    if (32'(max_cnt) >= MIN_COUNT) begin
      if ((work_r_q > work_g_q) && (work_r_q > work_b_q)) begin
        code_d = CodeRed;
      end else if ((work_g_q > work_r_q) && (work_g_q > work_b_q)) begin
        code_d = CodeGreen;
      end else if ((work_b_q > work_r_q) && (work_b_q > work_g_q)) begin
        code_d = CodeBlue;
      end
    end
  end

  // Measurement sequencer with registered filter selects, handshake and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      busy        <= 1'b0;
      color_code  <= CodeUnknown;
      color_valid <= 1'b0;
      red_cnt     <= '0;
      green_cnt   <= '0;
      blue_cnt    <= '0;
      work_r_q    <= '0;
      work_g_q    <= '0;
      work_b_q    <= '0;
    end else begin
      color_valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StSetR;
            timer_q      <= SettleLoad;
            {s2, s3}     <= SelRed;
            busy         <= 1'b1;
            work_r_q     <= '0;
            work_g_q     <= '0;
            work_b_q     <= '0;
          end
        end

        StSetR: begin
          if (timer_done) begin
            state_q <= StMeasR;
            timer_q <= GateLoad;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end

        StMeasR: begin
          if (sensor_rise) work_r_q <= sat_inc(work_r_q);
          if (timer_done) begin
            state_q  <= StSetG;
            timer_q  <= SettleLoad;
            {s2, s3} <= SelGreen;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end

        StSetG: begin
          if (timer_done) begin
            state_q <= StMeasG;
            timer_q <= GateLoad;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end

        StMeasG: begin
          if (sensor_rise) work_g_q <= sat_inc(work_g_q);
          if (timer_done) begin
            state_q  <= StSetB;
            timer_q  <= SettleLoad;
            {s2, s3} <= SelBlue;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end

        StSetB: begin
          if (timer_done) begin
            state_q <= StMeasB;
            timer_q <= GateLoad;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end

        StMeasB: begin
          if (sensor_rise) work_b_q <= sat_inc(work_b_q);
          if (timer_done) begin
            state_q  <= StDecide;
            timer_q  <= '0;
            {s2, s3} <= SelRed;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end

        StDecide: begin
          state_q     <= StIdle;
          timer_q     <= '0;
          busy        <= 1'b0;
          color_code  <= code_d;
          color_valid <= 1'b1;
          red_cnt     <= work_r_q;
          green_cnt   <= work_g_q;
          blue_cnt    <= work_b_q;
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcs3200_color_detector.sv
// tb_tcs3200_color_detector: random sensor waveforms per filter, recorded
// cycle by cycle; expected counts and colors are computed from the recording.
module tb_tcs3200_color_detector;

  localparam int unsigned G    = 100;
  localparam int unsigned S    = 10;
  localparam int unsigned MINC = 4;
  localparam int unsigned W8   = 8;
  localparam int unsigned W4   = 4;
  localparam int          SPAN = S + G;
  localparam int          RUN  = 3 * SPAN + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sensor_out;

  logic          s2, s3, busy, color_valid;
  logic [1:0]    color_code;
  logic [W8-1:0] red_cnt, green_cnt, blue_cnt;

  logic          s2_4, s3_4, busy_4, valid_4;
  logic [1:0]    code_4;
  logic [W4-1:0] red_4, green_4, blue_4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit samp [0:32767];

  int per_r = 10;
  int per_g = 40;
  int per_b = 40;
  bit dark  = 1'b0;

  tcs3200_color_detector #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (W8),
    .MIN_COUNT    (MINC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sensor_out (sensor_out),
    .s2         (s2),
    .s3         (s3),
    .busy       (busy),
    .color_code (color_code),
    .color_valid(color_valid),
    .red_cnt    (red_cnt),
    .green_cnt  (green_cnt),
    .blue_cnt   (blue_cnt)
  );

  tcs3200_color_detector #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (W4),
    .MIN_COUNT    (MINC)
  ) dut_w4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sensor_out (sensor_out),
    .s2         (s2_4),
    .s3         (s3_4),
    .busy       (busy_4),
    .color_code (code_4),
    .color_valid(valid_4),
    .red_cnt    (red_4),
    .green_cnt  (green_4),
    .blue_cnt   (blue_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record the sensor level as seen at every rising edge.
  always @(posedge clk) begin
    if (cyc < 32768) samp[cyc] <= sensor_out;
    cyc <= cyc + 1;
  end

  function automatic int cur_period();
    case ({s2, s3})
      2'b11:   return per_g;
      2'b01:   return per_b;
      default: return per_r;
    endcase
  endfunction

  // Sensor model: square wave whose period follows the selected filter.
  initial begin
    int half_left;
    half_left  = 1;
    sensor_out = 1'b0;
    forever begin
      @(negedge clk);
      if (dark) begin
        sensor_out = 1'b0;
        half_left  = 1;
      end else begin
        half_left = half_left - 1;
        if (half_left <= 0) begin
          sensor_out = ~sensor_out;
          half_left  = (cur_period() < 2) ? 1 : cur_period() / 2;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rising edges the synchronized detector credits to a gate starting at 'from'.
  function automatic int edges_in(input int from, input int len);
    int n = 0;
    for (int m = from; m < from + len; m++) begin
      if (m >= 1 && m < 32768 && samp[m] && !samp[m-1]) n++;
    end
    return n;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int classify(input int r, input int g, input int b);
    int mx = r;
    int nmax;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    nmax = ((r == mx) ? 1 : 0) + ((g == mx) ? 1 : 0) + ((b == mx) ? 1 : 0);
    if (nmax > 1 || mx < int'(MINC)) return 3;
    if (r == mx) return 0;
    if (g == mx) return 1;
    return 2;
  endfunction

  // t0 is the recorded index of the edge that sampled start.
  task automatic check_results(input int t0);
    int r, g, b;
    r = edges_in(t0 + S - 1, G);
    g = edges_in(t0 + S - 1 + SPAN, G);
    b = edges_in(t0 + S - 1 + 2 * SPAN, G);
    check("red_cnt", int'(red_cnt), sat(r, W8));
    check("green_cnt", int'(green_cnt), sat(g, W8));
    check("blue_cnt", int'(blue_cnt), sat(b, W8));
    check("color_code", int'(color_code),
          classify(sat(r, W8), sat(g, W8), sat(b, W8)));
    check("red_cnt_w4", int'(red_4), sat(r, W4));
    check("green_cnt_w4", int'(green_4), sat(g, W4));
    check("blue_cnt_w4", int'(blue_4), sat(b, W4));
    check("color_code_w4", int'(code_4),
          classify(sat(r, W4), sat(g, W4), sat(b, W4)));
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 9)) @(negedge clk);
  endtask

  // One measurement; restart_at is the edge index of a stray second start.
  task automatic run_one(input int restart_at, input int exp_code);
    int         t0;
    int         vfirst, vcount, v4first, seqerr, busy_end;
    logic [1:0] exp_ss;
    vfirst  = -1;
    v4first = -1;
    vcount  = 0;
    seqerr  = 0;
    busy_end = 1;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    for (int k = 0; k <= RUN + 4; k++) begin
      @(negedge clk);
      start = (k + 1 == restart_at) ? 1'b1 : 1'b0;
      if (k < 3 * SPAN) begin
        case (k / SPAN)
          0:       exp_ss = 2'b00;
          1:       exp_ss = 2'b11;
          default: exp_ss = 2'b01;
        endcase
        if ({s2, s3} !== exp_ss || busy !== 1'b1) seqerr++;
        if ({s2_4, s3_4} !== exp_ss || busy_4 !== 1'b1) seqerr++;
      end
      if (color_valid === 1'b1) begin
        vcount++;
        if (vfirst < 0) vfirst = k;
      end
      if (valid_4 === 1'b1 && v4first < 0) v4first = k;
      if (k == RUN) busy_end = int'(busy) + int'(busy_4);
    end
    check("valid_latency", vfirst, RUN);
    check("valid_latency_w4", v4first, RUN);
    check("valid_pulses", vcount, 1);
    check("s2s3_busy_seq", seqerr, 0);
    check("busy_after_valid", busy_end, 0);
    check("s2s3_idle", int'({s2, s3}), 0);
    check_results(t0);
    if (exp_code >= 0) check("plan_code", int'(color_code), exp_code);
  endtask

  task automatic run_continuous();
    int t0;
    int vpos[$];
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    for (int k = 0; k <= 2 * RUN + 5; k++) begin
      @(negedge clk);
      if (color_valid === 1'b1) vpos.push_back(k);
      if (k == 2 * RUN + 1) start = 1'b0;
    end
    check("cont_pulses", vpos.size(), 2);
    check("cont_first", (vpos.size() > 0) ? vpos[0] : -1, RUN);
    check("cont_second", (vpos.size() > 1) ? vpos[1] : -1, 2 * RUN + 1);
    check("cont_busy_end", int'(busy), 0);
    check_results(t0 + RUN + 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, int'(busy) + int'(busy_4), 0);
    check({tag, "_s2s3"}, int'({s2, s3, s2_4, s3_4}), 0);
    check({tag, "_code"}, int'(color_code), 3);
    check({tag, "_code_w4"}, int'(code_4), 3);
    check({tag, "_valid"}, int'(color_valid) + int'(valid_4), 0);
    check({tag, "_counts"}, int'(red_cnt) + int'(green_cnt) + int'(blue_cnt), 0);
    check({tag, "_counts_w4"}, int'(red_4) + int'(green_4) + int'(blue_4), 0);
  endtask

  task automatic run_reset_mid();
    int vcount = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SPAN + S + 30) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_s2s3", int'({s2, s3}), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_rst");
    repeat (RUN + 20) begin
      @(negedge clk);
      if (color_valid === 1'b1 || valid_4 === 1'b1) vcount++;
    end
    check("mid_rst_no_valid", vcount, 0);
    check("mid_rst_busy_later", int'(busy), 0);
  endtask

  initial begin
    int tie_opts[3] = '{4, 10, 20};
    int p;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Red dominant.
    per_r = $urandom_range(8, 12);
    per_g = $urandom_range(30, 50);
    per_b = $urandom_range(30, 50);
    gap();
    run_one(-1, 0);

    // Blue dominant.
    per_r = $urandom_range(20, 30);
    per_g = $urandom_range(20, 30);
    per_b = $urandom_range(6, 10);
    gap();
    run_one(-1, 2);

    // Identical even period on every filter: exact tie.
    p     = tie_opts[$urandom_range(0, 2)];
    per_r = p;
    per_g = p;
    per_b = p;
    gap();
    run_one(-1, 3);

    // Dark sensor.
    dark = 1'b1;
    gap();
    run_one(-1, 3);
    check("dark_counts", int'(red_cnt) + int'(green_cnt) + int'(blue_cnt), 0);
    dark = 1'b0;

    // Stray start mid-run, then continuous mode.
    per_r = $urandom_range(8, 12);
    per_g = $urandom_range(30, 50);
    per_b = $urandom_range(30, 50);
    gap();
    run_one(50, 0);
    gap();
    run_continuous();

    // Saturation of the narrow counter.
    per_r = $urandom_range(8, 14);
    per_g = 2;
    per_b = $urandom_range(8, 14);
    gap();
    run_one(-1, 1);
    check("sat_green_w4", int'(green_4), 15);
    check("sat_green_w8", int'(green_cnt), 50);
    check("sat_code_w4", int'(code_4), 1);

    // Abort mid-measurement, then a clean run.
    gap();
    run_reset_mid();
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_beats_start", int'(busy), 0);
    @(negedge clk);
    check("rst_beats_start_later", int'(busy), 0);
    per_r = $urandom_range(8, 12);
    per_g = $urandom_range(30, 50);
    per_b = $urandom_range(30, 50);
    gap();
    run_one(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
